airlock_sequencer: RTL and testbench

AIRLOCK_SEQUENCER -- requirements
Module: airlock_sequencer

---
 rtl/airlock_sequencer.sv | 176 +++++++++++++++++
 tb/tb_airlock_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/airlock_sequencer.sv
// rtl/airlock_sequencer.sv - two-door airlock sequencer for bath arrival/departure
//
// Purpose: sequences an airlock chamber through WAIT, FILL, OUTER-door and
// DRAIN phases for one arrival or departure at a time, interlocked against
// door switches. Any unexpected door opening latches FAULT until reset.
//
// Ports:
//   clk_clk                 sole clock, rising edge
//   reset_reset             synchronous active-high reset
//   batharriving_export     arrival request (level)
//   bathleaving_export      departure request (level)
//   personcheck_export      1 = occupant present in chamber
//   pressurecheck_export    1 = chamber pressure equalised with water
//   innerdoorswitch_export  1 = inner door physically open
//   outerdoorswitch_export  1 = outer door physically open
//   innerdoor_export        1 = inner door unlocked (IDLE)
//   outerdoor_export        1 = outer door unlocked (OUTER)
//   waiting/filling/draining_export            phase-active levels
//   waitfinished/fillfinished/drainfinished_export  one-cycle pulses on the
//                           first cycle of the following state
//   status_export           IDLE=0 WAIT=1 FILL=2 OUTER=3 DRAIN=4 FAULT=15

module airlock_sequencer #(
  parameter int unsigned WAIT_CYCLES  = 50,
  parameter int unsigned FILL_CYCLES  = 100,
  parameter int unsigned DRAIN_CYCLES = 100
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic       batharriving_export,
  input  logic       bathleaving_export,
  input  logic       personcheck_export,
  input  logic       pressurecheck_export,
  input  logic       innerdoorswitch_export,
  input  logic       outerdoorswitch_export,
  output logic       innerdoor_export,
  output logic       outerdoor_export,
  output logic       waiting_export,
  output logic       filling_export,
  output logic       draining_export,
  output logic       waitfinished_export,
  output logic       fillfinished_export,
  output logic       drainfinished_export,
  output logic [3:0] status_export
);

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_WAIT  = 4'd1,
    ST_FILL  = 4'd2,
    ST_OUTER = 4'd3,
    ST_DRAIN = 4'd4,
    ST_FAULT = 4'd15
  } state_t;

  // Counter value seen during the last cycle of each timed phase.
  localparam logic [15:0] LP_WAIT_LAST  = 16'(WAIT_CYCLES - 1);
  localparam logic [15:0] LP_FILL_LAST  = 16'(FILL_CYCLES - 1);
  localparam logic [15:0] LP_DRAIN_LAST = 16'(DRAIN_CYCLES - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_cnt;
  logic [15:0] w_next_cnt;
  logic        r_is_dep;      // accepted request was a departure
  logic        w_next_is_dep;
  logic        r_opened;      // outer door has been seen open during OUTER
  logic        w_next_opened;
  logic        w_any_door;
  logic        w_fill_done;

  assign w_any_door  = innerdoorswitch_export | outerdoorswitch_export;
  assign w_fill_done = (r_cnt >= LP_FILL_LAST);

  always_comb begin
    w_next_state  = r_state;
    w_next_cnt    = r_cnt;
    w_next_is_dep = r_is_dep;
    w_next_opened = r_opened;

    case (r_state)
      ST_IDLE: begin
        // Arrival has priority; a departure needs someone in the chamber.
        if (!w_any_door) begin
          if (batharriving_export) begin
            w_next_state  = ST_WAIT;
            w_next_is_dep = 1'b0;
          end else if (bathleaving_export && personcheck_export) begin
            w_next_state  = ST_WAIT;
            w_next_is_dep = 1'b1;
          end
        end
      end

      ST_WAIT: begin
        if (w_any_door)                  w_next_state = ST_FAULT;
        else if (r_cnt == LP_WAIT_LAST)  w_next_state = ST_FILL;
        else                             w_next_cnt   = r_cnt + 16'd1;
      end

      ST_FILL: begin
        // Counter saturates once the minimum fill time is reached; the
        // phase then holds until pressure is equalised.
        if (w_any_door)                                w_next_state = ST_FAULT;
        else if (w_fill_done && pressurecheck_export)  w_next_state = ST_OUTER;
        else if (!w_fill_done)                         w_next_cnt   = r_cnt + 16'd1;
      end

      ST_OUTER: begin
        // Leave only after the door has opened and closed again, with the
        // chamber occupied after an arrival or empty after a departure.
        if (innerdoorswitch_export) begin
          w_next_state = ST_FAULT;
        end else if (outerdoorswitch_export) begin
          w_next_opened = 1'b1;
        end else if (r_opened && (personcheck_export != r_is_dep)) begin
          w_next_state = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (w_any_door)                  w_next_state = ST_FAULT;
        else if (r_cnt == LP_DRAIN_LAST) w_next_state = ST_IDLE;
        else                             w_next_cnt   = r_cnt + 16'd1;
      end

      ST_FAULT: begin
        w_next_state = ST_FAULT;
      end

      default: begin
        w_next_state = ST_FAULT;
      end
    endcase

    // Every state entry starts with a fresh counter and opened flag.
    if (w_next_state != r_state) begin
      w_next_cnt    = 16'd0;
      w_next_opened = 1'b0;
    end
  end

  // Outputs are decoded from the next state so they line up with r_state.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_state              <= ST_IDLE;
      r_cnt                <= 16'd0;
      r_is_dep             <= 1'b0;
      r_opened             <= 1'b0;
      innerdoor_export     <= 1'b1;
      outerdoor_export     <= 1'b0;
      waiting_export       <= 1'b0;
      filling_export       <= 1'b0;
      draining_export      <= 1'b0;
      waitfinished_export  <= 1'b0;
      fillfinished_export  <= 1'b0;
      drainfinished_export <= 1'b0;
      status_export        <= 4'd0;
    end else begin
      r_state              <= w_next_state;
      r_cnt                <= w_next_cnt;
      r_is_dep             <= w_next_is_dep;
      r_opened             <= w_next_opened;
      innerdoor_export     <= (w_next_state == ST_IDLE);
      outerdoor_export     <= (w_next_state == ST_OUTER);
      waiting_export       <= (w_next_state == ST_WAIT);
      filling_export       <= (w_next_state == ST_FILL);
      draining_export      <= (w_next_state == ST_DRAIN);
      waitfinished_export  <= (r_state == ST_WAIT)  && (w_next_state == ST_FILL);
      fillfinished_export  <= (r_state == ST_FILL)  && (w_next_state == ST_OUTER);
      drainfinished_export <= (r_state == ST_DRAIN) && (w_next_state == ST_IDLE);
      status_export        <= w_next_state;
    end
  end

endmodule

// File: tb/tb_airlock_sequencer.sv
// tb/tb_airlock_sequencer.sv - directed self-checking bench for airlock_sequencer

module tb_airlock_sequencer;

  localparam int W = 2;
  localparam int F = 3;
  localparam int D = 2;

  // Per-edge expectations for a full arrival run; bit/entry k is edge k
  // counted from the edge that accepts the request.
  localparam logic [3:0]  ARR_ST [12] = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd3,
                                          4'd3, 4'd3, 4'd4, 4'd4, 4'd0, 4'd0};
  localparam logic [11:0] ARR_WF = 12'b0000_0000_0100;
  localparam logic [11:0] ARR_FF = 12'b0000_0010_0000;
  localparam logic [11:0] ARR_DF = 12'b0100_0000_0000;
  localparam logic [11:0] ARR_SW = 12'b0000_1100_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, arr, dep, person, pressure, in_sw, out_sw;
  logic       innerdoor, outerdoor, waiting, filling, draining;
  logic       wf, ff, df;
  logic [3:0] status;

  int n_checks = 0;
  int n_fail   = 0;

  airlock_sequencer #(
    .WAIT_CYCLES (W),
    .FILL_CYCLES (F),
    .DRAIN_CYCLES(D)
  ) dut (
    .clk_clk               (clk),
    .reset_reset           (rst),
    .batharriving_export   (arr),
    .bathleaving_export    (dep),
    .personcheck_export    (person),
    .pressurecheck_export  (pressure),
    .innerdoorswitch_export(in_sw),
    .outerdoorswitch_export(out_sw),
    .innerdoor_export      (innerdoor),
    .outerdoor_export      (outerdoor),
    .waiting_export        (waiting),
    .filling_export        (filling),
    .draining_export       (draining),
    .waitfinished_export   (wf),
    .fillfinished_export   (ff),
    .drainfinished_export  (df),
    .status_export         (status)
  );

  wire [11:0] obs = {innerdoor, outerdoor, waiting, filling, draining, wf, ff, df, status};

  // Expected output vector for a state code plus pulse values. FAULT (15)
  // decodes to all levels low.
  function automatic logic [11:0] exp_vec(input logic [3:0] st, input logic w, input logic f,
                                          input logic d);
    return {st == 4'd0, st == 4'd3, st == 4'd1, st == 4'd2, st == 4'd4, w, f, d, st};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; arr = 1'b0; dep = 1'b0; in_sw = 1'b0; out_sw = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; arr = 1'b1; dep = 1'b1; person = 1'b1; pressure = 1'b1;
    in_sw = 1'b0; out_sw = 1'b0;
    tick();
    n_checks++;
    if (obs !== 12'h800) begin
      n_fail++; $display("FAIL reset_state: got %h expected %h", obs, 12'h800);
    end
    rst = 1'b0; arr = 1'b0; dep = 1'b0;
    tick();
    n_checks++;
    if (obs !== 12'h800) begin
      n_fail++; $display("FAIL reset_idle_hold: got %h expected %h", obs, 12'h800);
    end
  endtask

  task automatic test_arrival();
    logic [11:0] e;
    do_reset();
    person = 1'b1; pressure = 1'b1; arr = 1'b1;
    for (int k = 0; k < 12; k++) begin
      out_sw = ARR_SW[k];
      tick();
      arr = 1'b0;
      e = exp_vec(ARR_ST[k], ARR_WF[k], ARR_FF[k], ARR_DF[k]);
      n_checks++;
      if (obs !== e) begin
        n_fail++; $display("FAIL arrival_seq[%0d]: got %h expected %h", k, obs, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    arr = 1'b1;
    tick();
    n_checks++;
    if (obs !== exp_vec(4'd1, 1'b0, 1'b0, 1'b0)) begin
      n_fail++; $display("FAIL back_to_back: got %h expected %h", obs, exp_vec(4'd1, 1'b0, 1'b0, 1'b0));
    end
    arr = 1'b0;
  endtask

  task automatic test_door_gating();
    do_reset();
    person = 1'b1; arr = 1'b1; in_sw = 1'b1;
    tick();
    n_checks++;
    if (obs !== 12'h800) begin
      n_fail++; $display("FAIL gate_inner_open: got %h expected %h", obs, 12'h800);
    end
    in_sw = 1'b0; out_sw = 1'b1;
    tick();
    n_checks++;
    if (obs !== 12'h800) begin
      n_fail++; $display("FAIL gate_outer_open: got %h expected %h", obs, 12'h800);
    end
    out_sw = 1'b0; arr = 1'b0;
  endtask

  task automatic test_departure();
    do_reset();
    person = 1'b0; pressure = 1'b1; dep = 1'b1;
    tick();
    n_checks++;
    if (obs !== 12'h800) begin
      n_fail++; $display("FAIL dep_no_person: got %h expected %h", obs, 12'h800);
    end
    person = 1'b1;
    tick();
    n_checks++;
    if (obs !== exp_vec(4'd1, 1'b0, 1'b0, 1'b0)) begin
      n_fail++; $display("FAIL dep_accept: got %h expected %h", obs, exp_vec(4'd1, 1'b0, 1'b0, 1'b0));
    end
    dep = 1'b0;
    repeat (5) tick();
    n_checks++;
    if (obs !== exp_vec(4'd3, 1'b0, 1'b1, 1'b0)) begin
      n_fail++; $display("FAIL dep_outer: got %h expected %h", obs, exp_vec(4'd3, 1'b0, 1'b1, 1'b0));
    end
    out_sw = 1'b1;
    tick();
    out_sw = 1'b0;
    repeat (2) begin
      tick();
      n_checks++;
      if (obs !== exp_vec(4'd3, 1'b0, 1'b0, 1'b0)) begin
        n_fail++; $display("FAIL dep_hold_occupied: got %h expected %h", obs, exp_vec(4'd3, 1'b0, 1'b0, 1'b0));
      end
    end
    person = 1'b0;
    tick();
    n_checks++;
    if (obs !== exp_vec(4'd4, 1'b0, 1'b0, 1'b0)) begin
      n_fail++; $display("FAIL dep_drain: got %h expected %h", obs, exp_vec(4'd4, 1'b0, 1'b0, 1'b0));
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    person = 1'b1; pressure = 1'b1; arr = 1'b1; dep = 1'b1;
    tick();
    arr = 1'b0; dep = 1'b0;
    repeat (5) tick();
    n_checks++;
    if (obs !== exp_vec(4'd3, 1'b0, 1'b1, 1'b0)) begin
      n_fail++; $display("FAIL simul_outer: got %h expected %h", obs, exp_vec(4'd3, 1'b0, 1'b1, 1'b0));
    end
    out_sw = 1'b1;
    tick();
    out_sw = 1'b0; person = 1'b0;
    repeat (2) begin
      tick();
      n_checks++;
      if (obs !== exp_vec(4'd3, 1'b0, 1'b0, 1'b0)) begin
        n_fail++; $display("FAIL simul_hold_empty: got %h expected %h", obs, exp_vec(4'd3, 1'b0, 1'b0, 1'b0));
      end
    end
    person = 1'b1;
    tick();
    n_checks++;
    if (obs !== exp_vec(4'd4, 1'b0, 1'b0, 1'b0)) begin
      n_fail++; $display("FAIL simul_drain: got %h expected %h", obs, exp_vec(4'd4, 1'b0, 1'b0, 1'b0));
    end
  endtask

  task automatic test_fill_hold();
    int fill_n;
    int ff_n;
    do_reset();
    person = 1'b1; pressure = 1'b0; arr = 1'b1;
    tick();
    arr = 1'b0;
    fill_n = 0; ff_n = 0;
    for (int k = 1; k <= 14; k++) begin
      if (k == 10) pressure = 1'b1;
      tick();
      fill_n += int'(filling);
      ff_n   += int'(ff);
    end
    n_checks++;
    if (fill_n != F + 5) begin
      n_fail++; $display("FAIL fill_hold_len: got %0d expected %0d", fill_n, F + 5);
    end
    n_checks++;
    if (ff_n != 1) begin
      n_fail++; $display("FAIL fill_hold_pulses: got %0d expected %0d", ff_n, 1);
    end
    n_checks++;
    if (status !== 4'd3) begin
      n_fail++; $display("FAIL fill_hold_exit: got %0d expected %0d", status, 3);
    end
  endtask

  task automatic test_fault();
    do_reset();
    person = 1'b1; pressure = 1'b1; arr = 1'b1;
    tick();
    arr = 1'b0;
    repeat (5) tick();
    out_sw = 1'b1;
    tick();
    out_sw = 1'b0;
    tick();
    n_checks++;
    if (obs !== exp_vec(4'd4, 1'b0, 1'b0, 1'b0)) begin
      n_fail++; $display("FAIL fault_pre_drain: got %h expected %h", obs, exp_vec(4'd4, 1'b0, 1'b0, 1'b0));
    end
    in_sw = 1'b1;
    tick();
    n_checks++;
    if (obs !== 12'h00F) begin
      n_fail++; $display("FAIL fault_drain_inner: got %h expected %h", obs, 12'h00F);
    end
    in_sw = 1'b0; arr = 1'b1;
    repeat (2) tick();
    n_checks++;
    if (obs !== 12'h00F) begin
      n_fail++; $display("FAIL fault_sticky: got %h expected %h", obs, 12'h00F);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; arr = 1'b0;
    n_checks++;
    if (obs !== 12'h800) begin
      n_fail++; $display("FAIL fault_reset: got %h expected %h", obs, 12'h800);
    end
    arr = 1'b1;
    tick();
    arr = 1'b0; out_sw = 1'b1;
    tick();
    out_sw = 1'b0;
    n_checks++;
    if (obs !== 12'h00F) begin
      n_fail++; $display("FAIL fault_wait_outer: got %h expected %h", obs, 12'h00F);
    end
    do_reset();
    arr = 1'b1;
    tick();
    arr = 1'b0;
    repeat (5) tick();
    in_sw = 1'b1;
    tick();
    in_sw = 1'b0;
    n_checks++;
    if (obs !== 12'h00F) begin
      n_fail++; $display("FAIL fault_outer_inner: got %h expected %h", obs, 12'h00F);
    end
  endtask

  task automatic test_reset_mid_fill();
    do_reset();
    person = 1'b1; pressure = 1'b0; arr = 1'b1;
    tick();
    arr = 1'b0;
    repeat (2) tick();
    n_checks++;
    if (status !== 4'd2) begin
      n_fail++; $display("FAIL midfill_in_fill: got %0d expected %0d", status, 2);
    end
    repeat (2) tick();
    pressure = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (obs !== 12'h800) begin
      n_fail++; $display("FAIL midfill_reset: got %h expected %h", obs, 12'h800);
    end
    tick();
    n_checks++;
    if (obs !== 12'h800) begin
      n_fail++; $display("FAIL midfill_no_pulse: got %h expected %h", obs, 12'h800);
    end
  endtask

  initial begin
    rst = 1'b1; arr = 1'b0; dep = 1'b0; person = 1'b0; pressure = 1'b0;
    in_sw = 1'b0; out_sw = 1'b0;
    test_reset();
    test_arrival();
    test_back_to_back();
    test_door_gating();
    test_departure();
    test_simultaneous();
    test_fill_hold();
    test_fault();
    test_reset_mid_fill();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
